// File: rtl/aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_mode_ctrl
// Function : Valid/ready block sequencer for aes_core with ECB/CBC/CTR chaining.
// Revision : 1.0 - initial release
// ============================================================================
module aes_mode_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start_i,
    input  logic [255:0]     cfg_key_i,
    input  logic [127:0]     cfg_iv_i,
    input  logic [1:0]       cfg_size_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic             cfg_dec_i,
    output logic             cfg_err_o,
    input  logic             in_valid_i,
    input  logic [127:0]     in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [127:0]     out_data_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic             core_load_o,
    output logic [255:0]     core_key_o,
    output logic [127:0]     core_data_o,
    output logic [1:0]       core_size_o,
    output logic             core_dec_o,
    input  logic [127:0]     core_data_i,
    input  logic             core_busy_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [1:0] C_MODE_CBC = 2'd1;
    localparam logic [1:0] C_MODE_CTR = 2'd2;
    localparam logic [1:0] C_MODE_ILL = 2'd3;

    state_t             state_q, state_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         mode_q, mode_d;
    logic               dec_q, dec_d;
    logic               err_q, err_d;
    logic [127:0]       chain_q, chain_d;
    logic [127:0]       blk_q, blk_d;
    logic [127:0]       core_in_q, core_in_d;
    logic [127:0]       out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        size_d    = size_q;
        mode_d    = mode_q;
        dec_d     = dec_q;
        err_d     = err_q;
        chain_d   = chain_q;
        blk_d     = blk_q;
        core_in_d = core_in_q;
        out_d     = out_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE, S_READY: begin
                if (cfg_start_i) begin
                    state_d = S_READY;
                    key_d   = cfg_key_i;
                    size_d  = cfg_size_i;
                    mode_d  = cfg_mode_i;
                    // CTR always runs the core forward, whatever direction was asked for
                    dec_d   = cfg_dec_i && (cfg_mode_i != C_MODE_CTR);
                    err_d   = (cfg_mode_i == C_MODE_ILL);
                    chain_d = cfg_iv_i;
                    cnt_d   = '0;
                end else if ((state_q == S_READY) && in_valid_i) begin
                    state_d = S_LOAD;
                    blk_d   = in_data_i;
                    case (mode_q)
                        C_MODE_CBC: core_in_d = dec_q ? in_data_i : (in_data_i ^ chain_q);
                        C_MODE_CTR: core_in_d = chain_q;
                        default:    core_in_d = in_data_i;
                    endcase
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!core_busy_i) begin
                    state_d = S_OUT;
                    cnt_d   = cnt_q + CNT_W'(1);
                    case (mode_q)
                        C_MODE_CBC: begin
                            if (dec_q) begin
                                out_d   = core_data_i ^ chain_q;
                                chain_d = blk_q;
                            end else begin
                                out_d   = core_data_i;
                                chain_d = core_data_i;
                            end
                        end
                        C_MODE_CTR: begin
                            out_d   = blk_q ^ core_data_i;
                            chain_d = {chain_q[127:32], chain_q[31:0] + 32'd1};
                        end
                        default: out_d = core_data_i;
                    endcase
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            size_q    <= '0;
            mode_q    <= '0;
            dec_q     <= 1'b0;
            err_q     <= 1'b0;
            chain_q   <= '0;
            blk_q     <= '0;
            core_in_q <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            size_q    <= size_d;
            mode_q    <= mode_d;
            dec_q     <= dec_d;
            err_q     <= err_d;
            chain_q   <= chain_d;
            blk_q     <= blk_d;
            core_in_q <= core_in_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    // A start pulse in READY takes priority over a waiting input block
    assign in_ready_o  = (state_q == S_READY) && !cfg_start_i;
    assign core_load_o = (state_q == S_LOAD);
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_OUT);
    assign cfg_err_o   = err_q;
    assign out_data_o  = out_q;
    assign blk_cnt_o   = cnt_q;
    assign core_key_o  = key_q;
    assign core_data_o = core_in_q;
    assign core_size_o = size_q;
    assign core_dec_o  = dec_q;

endmodule
`default_nettype wire

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Initiator-side sequencer for the aes_core load/busy interface; streams 128-bit blocks through one core instance.
- Applies ECB, CBC or CTR chaining around each core operation.
- Sits between the bus/DMA stream (valid/ready in and out) and aes_core, which has no flow control of its own.

Parameters:
CNT_W, 32, width of completed-block counter blk_cnt_o

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_start_i  input  1  one-cycle pulse; latches key/iv/size/mode/dec, clears chain state and counter
cfg_key_i  input  256  key; passed to core unmodified (bit placement per core key schedule)
cfg_iv_i  input  128  IV (CBC) or initial counter block (CTR)
cfg_size_i  input  2  0=AES-128, 1=AES-192, 2/3=AES-256
cfg_mode_i  input  2  0=ECB, 1=CBC, 2=CTR, 3=illegal
cfg_dec_i  input  1  1=decrypt (ignored in CTR)
cfg_err_o  output  1  sticky: illegal mode latched; cleared by next cfg_start_i
in_valid_i  input  1  input block valid
in_data_i  input  128  input block
in_ready_o  output  1  controller accepts block
out_valid_o  output  1  result valid
out_data_o  output  128  result block
out_ready_i  input  1  downstream accepts result
busy_o  output  1  block in flight (LOAD, WAIT or OUT)
blk_cnt_o  output  CNT_W  blocks completed since last cfg_start_i, wraps
core_load_o  output  1  to aes_core load_i
core_key_o  output  256  to aes_core key_i (registered, held)
core_data_o  output  128  to aes_core data_i (registered)
core_size_o  output  2  to aes_core size_i
core_dec_o  output  1  to aes_core dec_i
core_data_i  input  128  from aes_core data_o
core_busy_i  input  1  from aes_core busy_o

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - Outputs 0: core_load_o, out_valid_o, in_ready_o, busy_o, cfg_err_o.
  - Cleared to 0: blk_cnt_o, out_data_o, core_* registers, chain/counter registers.
- States: IDLE, READY, LOAD, WAIT, OUT.
- IDLE: in_ready_o=0. cfg_start_i -> READY.
- READY:
  - in_ready_o = ~cfg_start_i.
  - cfg_start_i re-latches config and stays in READY.
  - On in_valid_i & in_ready_o: register core_data_o, then -> LOAD.
- LOAD: core_load_o=1 for exactly this one cycle -> WAIT. core_busy_i is ignored in LOAD because its value is stale.
- WAIT:
  - Stays while core_busy_i=1.
  - First cycle with core_busy_i=0: compute result into out_data_o, update chain, blk_cnt_o+1 -> OUT.
  - Load is never reissued while in WAIT.
- OUT:
  - out_valid_o=1; out_data_o stable.
  - out_ready_i -> READY; next block accepted no earlier than the following cycle.
- cfg_start_i in LOAD/WAIT/OUT: ignored (no abort).
- Core input / output per mode (chain = 128-bit register, loaded from cfg_iv_i at cfg_start_i):
  - ECB: core_in=P; out=core_data_i; core_dec_o=cfg_dec.
  - CBC enc: core_in=P^chain; out=core_data_i; chain<=core_data_i.
  - CBC dec: core_in=C; out=core_data_i^chain; chain<=C (captured at input handshake).
  - CTR: core_in=chain; out=in_block^core_data_i; core_dec_o=0 forced. chain[31:0]<=chain[31:0]+1, wrapping 0xFFFFFFFF->0; chain[127:32] unchanged.
- Illegal mode 3: behaves as ECB; cfg_err_o=1.
- core_key_o, core_size_o and core_dec_o are registered at cfg_start_i and held constant (the core re-expands the key on every load).
- Latency from input handshake edge to out_valid_o: 2 + core busy duration.
  - AES-128 encrypt: 11 busy cycles -> out_valid_o 13 cycles after handshake.
  - AES-128 decrypt: 22 busy cycles.
- blk_cnt_o wraps modulo 2^CNT_W.
- Reset mid-operation: core_load_o drops immediately; the core may still be busy. The next LOAD restarts the core because load_i has priority in aes_core.

Test Plan:
- ECB AES-128 enc, FIPS-197 key 000102..0f, P=00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid_o 13 cycles after handshake; blk_cnt_o=1.
- ECB AES-128 dec of 69c4e0d86a7b0430d8cdb78070b4c55a, same key -> 00112233445566778899aabbccddeeff; core_load_o high exactly 1 cycle.
- CBC enc then CBC dec of SP800-38A F.2.1 (4 blocks, AES-128) -> ciphertexts match; plaintext round-trips; chain reset by new cfg_start_i.
- CTR with IV low word FFFFFFFF, 2 blocks -> second core_data_o has low word 00000000, upper 96 bits unchanged; core_dec_o=0 although cfg_dec_i=1.
- Backpressure: out_ready_i held 0 for 20 cycles -> out_valid_o/out_data_o stable, in_ready_o=0, no core_load_o; then release -> READY.
- cfg_start_i in WAIT ignored; cfg_mode_i=3 -> cfg_err_o=1 with ECB result; rst_n pulse in WAIT -> all outputs 0 immediately, state IDLE.
